// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the fp_* arithmetic blocks: default Q32.32 format,
// divider state encoding and saturation limits.
package fp_pkg;
    localparam int FP_WIDTH      = 64;
    localparam int FP_INT_WIDTH  = 32;
    localparam int FP_FRAC_WIDTH = 32;

    localparam logic [FP_WIDTH-1:0] FP_MAX_POS = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0] FP_MIN_NEG = {1'b1, {(FP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;
endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, emit quotient bit.
// Purely combinational; no flow control.
module fp_div_step #(
    parameter int N  = 96,
    parameter int DW = 64
) (
    input  logic [N-1:0]  rem_in,
    input  logic          dvd_bit,
    input  logic [DW-1:0] divisor,
    output logic [N-1:0]  rem_out,
    output logic          q_bit
);
    logic [N-1:0] shifted;
    logic [N-1:0] dvs_ext;

    // The bit shifted out of rem_in counts as an implicit 2^N, so the subtract is still valid mod 2^N.
    always_comb begin
        dvs_ext = {{(N-DW){1'b0}}, divisor};
        shifted = {rem_in[N-2:0], dvd_bit};
        q_bit   = rem_in[N-1] | (shifted >= dvs_ext);
        rem_out = q_bit ? (shifted - dvs_ext) : shifted;
    end
endmodule

// File: rtl/fp_div.sv
// Signed Qi.f divider, truncating toward zero with saturation; fixed WIDTH+FRAC_WIDTH+2 edge latency.
// Level-held go acts as the handshake: dropping it aborts or acknowledges, clearing the outputs.
module fp_div
    import fp_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH,
    parameter int INT_WIDTH  = FP_INT_WIDTH,
    parameter int FRAC_WIDTH = FP_FRAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             go,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             div_by_zero
);
    localparam int N  = WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [N-1:0]     LIM     = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = FP_MAX_POS[FP_WIDTH-1 -: WIDTH];
    localparam logic [WIDTH-1:0] MIN_NEG = FP_MIN_NEG[FP_WIDTH-1 -: WIDTH];

    if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
        $error("fp_div: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
    end

    div_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     rem, quo, rem_nxt;
    logic [WIDTH-1:0] dvs, abs_left, abs_right, fix_out;
    logic             sign, zero, q_bit;

    fp_div_step #(.N(N), .DW(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (quo[N-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        abs_left  = left[WIDTH-1]  ? -left  : left;
        abs_right = right[WIDTH-1] ? -right : right;
    end

    // Negative results may reach 2^(WIDTH-1) exactly; positive ones stop one short.
    always_comb begin
        fix_out = quo[WIDTH-1:0];
        if (zero)
            fix_out = sign ? MIN_NEG : MAX_POS;
        else if (!sign)
            fix_out = (quo >= LIM) ? MAX_POS : quo[WIDTH-1:0];
        else
            fix_out = (quo > LIM) ? MIN_NEG : -quo[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!go) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CALC;
                CALC:    if (cnt == LAST) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            sign        <= 1'b0;
            zero        <= 1'b0;
            out         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (!go) begin
            out         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    quo  <= {abs_left, {FRAC_WIDTH{1'b0}}};
                    rem  <= '0;
                    dvs  <= abs_right;
                    sign <= left[WIDTH-1] ^ right[WIDTH-1];
                    zero <= (right == '0);
                    cnt  <= '0;
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    out         <= fix_out;
                    done        <= 1'b1;
                    div_by_zero <= zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div (Q32.32): directed cases, abort/reset handling,
// and random operands against a wide-integer reference model.
module tb_fp_div;
    import fp_pkg::*;

    localparam int W     = 64;
    localparam int LAT   = 98;
    localparam int LIMIT = 200;
    localparam logic signed [127:0] QMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] QMIN = -128'sh8000_0000_0000_0000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] left  = '0;
    logic [W-1:0] right = '0;
    logic         go    = 1'b0;
    logic [W-1:0] out;
    logic         done;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_div #(.WIDTH(64), .INT_WIDTH(32), .FRAC_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .left        (left),
        .right       (right),
        .go          (go),
        .out         (out),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, out}: exact signed quotient of (l * 2^32) / r, then clamped.
    function automatic logic [W:0] model(input logic [W-1:0] l, input logic [W-1:0] r);
        logic signed [127:0] num, den, q;
        if (r == '0) return {1'b1, (l[W-1] ? FP_MIN_NEG : FP_MAX_POS)};
        num = $signed(l);
        num = num <<< 32;
        den = $signed(r);
        q   = num / den;
        if (q > QMAX) return {1'b0, FP_MAX_POS};
        if (q < QMIN) return {1'b0, FP_MIN_NEG};
        return {1'b0, q[W-1:0]};
    endfunction

    // Entered just after a falling edge with the DUT idle; returns the edge count at which done rose.
    task automatic start_and_wait(input logic [W-1:0] l, input logic [W-1:0] r, output int edges);
        left  = l;
        right = r;
        go    = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!done && edges < LIMIT);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [W-1:0] exp_out, input logic exp_dbz);
        int e;
        start_and_wait(l, r, e);
        check({tag, "_lat"}, W'(e), W'(LAT));
        check({tag, "_done"}, done, 1);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        left  = ~l;
        right = l;
        @(negedge clk);
        check({tag, "_hold"}, out, exp_out);
        go = 1'b0;
        @(negedge clk);
        check({tag, "_clr"}, {out[W-2:0], done}, 0);
    endtask

    initial begin
        logic [W:0]   m;
        logic [W-1:0] l, r;
        int           e;

        #1 rst_n = 1'b0;
        #2;
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("div_6_2",  64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 1'b0);
        do_op("div_m1_4", 64'hFFFF_FFFF_0000_0000, 64'h0000_0004_0000_0000, 64'hFFFF_FFFF_C000_0000, 1'b0);
        do_op("div_1_3",  64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0000_5555_5555, 1'b0);
        do_op("div_5_0",  64'h0000_0005_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        do_op("div_m5_0", 64'hFFFF_FFFB_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 1'b1);
        do_op("sat_pos",  64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        do_op("sat_minq", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        do_op("min_neg",  64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 1'b0);

        // Abort: go sampled low at edge 50.
        left  = 64'h0000_0006_0000_0000;
        right = 64'h0000_0002_0000_0000;
        go    = 1'b1;
        repeat (49) @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        check("abort_clr", {out[W-2:0], done}, 0);
        do_op("after_abort", 64'h0000_0007_0000_0000, 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFC_8000_0000, 1'b0);

        // Reset mid-calculation, between clock edges.
        left  = 64'h0000_0006_0000_0000;
        right = 64'h0000_0002_0000_0000;
        go    = 1'b1;
        repeat (60) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out", out, 0);
        check("rst_mid_done", done, 0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 1'b0);

        // Reset while results are held: outputs must drop without a clock edge.
        start_and_wait(64'h0000_0005_0000_0000, 64'h0, e);
        check("rst_done_pre", {div_by_zero, done}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_hold_out", out, 0);
        check("rst_hold_flags", {div_by_zero, done}, 0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            l = {$urandom, $urandom};
            r = {$urandom, $urandom};
            l = $signed(l) >>> $urandom_range(0, 62);
            r = $signed(r) >>> $urandom_range(0, 62);
            if ($urandom_range(0, 9) == 0) r = '0;
            m = model(l, r);
            do_op($sformatf("rnd%0d", i), l, r, m[W-1:0], m[W]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter WIDTH, default 64, total signed fixed-point word width.
REQ-002 SHALL have parameter INT_WIDTH, default 32, integer bits including sign.
REQ-003 SHALL have parameter FRAC_WIDTH, default 32, fraction bits; WIDTH = INT_WIDTH + FRAC_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port left  input  WIDTH  signed Qi.f dividend.
REQ-007 SHALL have port right  input  WIDTH  signed Qi.f divisor.
REQ-008 SHALL have port go  input  1  level request; held high until done is observed.
REQ-009 SHALL have port out  output  WIDTH  signed Qi.f quotient, registered.
REQ-010 SHALL have port done  output  1  result valid, registered.
REQ-011 SHALL have port div_by_zero  output  1  right was zero, valid while done=1.

Function
REQ-012 SHALL compute out = trunc-toward-zero((left << FRAC_WIDTH) / right) on two's-complement values.
REQ-013 SHALL use states IDLE, CALC, FIX, DONE.
REQ-014 IDLE: go=1 at edge -> latch |left|, |right|, sign = left[MSB]^right[MSB], zero flag, bit counter=0; go to CALC.
REQ-015 CALC: one restoring-division step per edge, one quotient bit per edge, WIDTH+FRAC_WIDTH steps; after the last step go to FIX.
REQ-016 Quotient/remainder registers SHALL be WIDTH+FRAC_WIDTH bits wide; magnitude of most-negative operand (2^(WIDTH-1)) SHALL be representable.
REQ-017 FIX: apply sign, saturate, register out, set done=1; go to DONE.
REQ-018 Saturation: positive magnitude > 2^(WIDTH-1)-1 -> out = 0x7FF..F; negative magnitude > 2^(WIDTH-1) -> out = 0x800..0.
REQ-019 right == 0: div_by_zero=1, out = 0x7FF..F if left >= 0 else 0x800..0; latency unchanged.
REQ-020 Latency fixed: done=1 after edge WIDTH+FRAC_WIDTH+2 (98 for defaults), counting the first edge sampling go=1 as edge 1.
REQ-021 DONE: out, done, div_by_zero hold while go=1; operand changes ignored.
REQ-022 go=0 in any state -> next edge: state IDLE, out=0, done=0, div_by_zero=0 (abort mid-CALC allowed).
REQ-023 New operation requires go low for >=1 edge after done; no back-to-back restart from DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out=0, done=0, div_by_zero=0, counter and datapath registers 0, regardless of clk.
REQ-025 After rst_n rises, first go=1 edge SHALL start a fresh operation with full latency.

Structure
REQ-026 Package fp_pkg SHALL hold default WIDTH/INT_WIDTH/FRAC_WIDTH, state enum type, and saturation constants (max positive, min negative), shared with mult/add/sub.
REQ-027 Sub-module fp_div_step (combinational: shift remainder, compare, conditional subtract, emit quotient bit) SHALL be instantiated once; no other sub-modules.

Verification (defaults, Q32.32 hex)
REQ-028 6.0/2.0: left=0x0000_0006_0000_0000, right=0x0000_0002_0000_0000 -> out=0x0000_0003_0000_0000, done rises exactly at edge 98.
REQ-029 -1.0/4.0: left=0xFFFF_FFFF_0000_0000, right=0x0000_0004_0000_0000 -> out=0xFFFF_FFFF_C000_0000; 1.0/3.0 -> out=0x0000_0000_5555_5555.
REQ-030 5.0/0 -> out=0x7FFF_FFFF_FFFF_FFFF, div_by_zero=1; -5.0/0 -> out=0x8000_0000_0000_0000, div_by_zero=1.
REQ-031 0x4000_0000_0000_0000 / 0x0000_0000_0000_0001 -> out=0x7FFF_FFFF_FFFF_FFFF; 0x8000_0000_0000_0000 / 0xFFFF_FFFF_0000_0000 (-1.0) -> out=0x7FFF_FFFF_FFFF_FFFF.
REQ-032 go dropped at edge 50 -> done=0, out=0 next edge; go re-raised -> correct result at full 98-edge latency.
REQ-033 rst_n pulsed low at edge 60 -> out=0, done=0 with no clock edge; operation after release completes correctly.
